// File: rtl/led_sequencer.sv
// led_sequencer
//   Front-panel LED sequencer: slow fill, fast fill and blink patterns on an
//   N_LEDS-wide LED bar, with a countdown / blink code for the 7-seg decoder.
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   start_n  in   start button, active-low, asynchronous to clk
//   mode     in   2'b00 idle, 01 slow fill, 10 fast fill, 11 blink
//   led_out  out  LED bar, bit 0 lights first
//   count    out  countdown (fill) or BLINK_CODE (blink)
//   busy     out  high while filling or blinking
//   done     out  one-cycle pulse when a fill completes
module led_sequencer #(
    parameter int N_LEDS     = 10,
    parameter int FAST_LEN   = 8,
    parameter int SLOW_DIV   = 50_000_000,
    parameter int FAST_DIV   = 25_000_000,
    parameter int CNT_W      = 4,
    parameter int BLINK_CODE = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_n,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] led_out,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done
);

    localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int TW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam int FW      = $clog2(N_LEDS + 1);

    localparam logic [TW-1:0]    SLOW_LAST  = TW'(SLOW_DIV - 1);
    localparam logic [TW-1:0]    FAST_LAST  = TW'(FAST_DIV - 1);
    localparam logic [FW-1:0]    SLOW_TICKS = FW'(N_LEDS);
    localparam logic [FW-1:0]    FAST_TICKS = FW'(FAST_LEN);
    localparam logic [CNT_W-1:0] SLOW_CNT0  = CNT_W'(N_LEDS);
    localparam logic [CNT_W-1:0] FAST_CNT0  = CNT_W'((FAST_LEN + 1) / 2);
    localparam logic [CNT_W-1:0] BLINK_VAL  = CNT_W'(BLINK_CODE);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_BLINK, S_DONE} state_t;

    state_t            state, state_n;
    logic [1:0]        run_mode, run_mode_n;
    logic [TW-1:0]     tcnt, tcnt_n;
    logic [FW-1:0]     ftk, ftk_n;          // fill ticks taken so far
    logic [N_LEDS-1:0] led_n;
    logic [CNT_W-1:0]  count_n;
    logic              busy_n, done_n;

    // Start synchroniser. Flops reset to 0 ("pressed") so a button held
    // through reset release never looks like a fresh high->low edge.
    logic s1, s2, s2_d;
    logic start_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= start_n;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign start_pulse = s2_d & ~s2;

    logic          tick;
    logic [FW-1:0] ftk_inc;
    logic [FW-1:0] fill_len;
    logic          go_idle;

    assign tick     = (run_mode == 2'b10) ? (tcnt == FAST_LAST) : (tcnt == SLOW_LAST);
    assign ftk_inc  = ftk + 1'b1;
    assign fill_len = (run_mode == 2'b01) ? SLOW_TICKS : FAST_TICKS;
    // mode=00 always wins; a mode mismatch only aborts when no restart is pending
    assign go_idle  = (mode == 2'b00) ||
                      (!start_pulse && state != S_IDLE && mode != run_mode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            run_mode <= 2'b00;
            tcnt     <= '0;
            ftk      <= '0;
            led_out  <= '0;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            run_mode <= run_mode_n;
            tcnt     <= tcnt_n;
            ftk      <= ftk_n;
            led_out  <= led_n;
            count    <= count_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        run_mode_n = run_mode;
        tcnt_n     = tcnt;
        ftk_n      = ftk;
        led_n      = led_out;
        count_n    = count;
        busy_n     = busy;
        done_n     = 1'b0;

        if (state == S_FILL || state == S_BLINK)
            tcnt_n = tick ? '0 : tcnt + 1'b1;

        if (go_idle) begin
            state_n    = S_IDLE;
            run_mode_n = 2'b00;
            tcnt_n     = '0;
            ftk_n      = '0;
            led_n      = '0;
            count_n    = '0;
            busy_n     = 1'b0;
        end else if (start_pulse) begin
            run_mode_n = mode;
            tcnt_n     = '0;
            ftk_n      = '0;
            led_n      = '0;
            busy_n     = 1'b1;
            case (mode)
                2'b01:   begin count_n = SLOW_CNT0; state_n = S_FILL;  end
                2'b10:   begin count_n = FAST_CNT0; state_n = S_FILL;  end
                default: begin count_n = BLINK_VAL; state_n = S_BLINK; end
            endcase
        end else begin
            case (state)
                S_FILL: if (tick) begin
                    led_n = {led_out[N_LEDS-2:0], 1'b1};
                    ftk_n = ftk_inc;
                    // fast fill only counts down on even-numbered ticks
                    if ((run_mode == 2'b01 || !ftk_inc[0]) && count != '0)
                        count_n = count - 1'b1;
                    if (ftk_inc == fill_len) begin
                        state_n = S_DONE;
                        tcnt_n  = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end
                S_BLINK: if (tick) led_n = ~led_out;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;

    localparam int N    = 10;
    localparam int FL   = 8;
    localparam int SDIV = 4;
    localparam int FDIV = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_n = 1'b1;
    logic [1:0]   mode = 2'b00;
    logic [N-1:0] led_out;
    logic [3:0]   count;
    logic         busy, done;

    int total = 0;
    int bad   = 0;

    led_sequencer #(
        .N_LEDS(N), .FAST_LEN(FL), .SLOW_DIV(SDIV), .FAST_DIV(FDIV),
        .CNT_W(4), .BLINK_CODE(10)
    ) dut (
        .clk(clk), .rst(rst), .start_n(start_n), .mode(mode),
        .led_out(led_out), .count(count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: remembers the start_n samples, the active run mode and
    // the cycles elapsed since the start edge; outputs follow arithmetically.
    int sm1 = 0, sm2 = 0, sm3 = 0;
    bit act = 0;
    int mm  = 0;
    int el  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sm1 = 0; sm2 = 0; sm3 = 0;
            act = 0; el = 0; mm = 0;
        end else begin
            bit pulse;
            pulse = (sm3 == 1 && sm2 == 0);
            if (mode == 2'b00) act = 0;
            else if (pulse) begin act = 1; mm = int'(mode); el = 0; end
            else if (act && int'(mode) != mm) act = 0;
            else if (act) el++;
            sm3 = sm2; sm2 = sm1; sm1 = int'(start_n);
        end
    end

    function automatic void model_out(output int l, output int c, output int b, output int d);
        int t, m;
        l = 0; c = 0; b = 0; d = 0;
        if (act) begin
            case (mm)
                1: begin
                    t = el / SDIV; m = (t < N) ? t : N;
                    l = (1 << m) - 1; c = N - m;
                    b = (el < N * SDIV) ? 1 : 0; d = (el == N * SDIV) ? 1 : 0;
                end
                2: begin
                    t = el / FDIV; m = (t < FL) ? t : FL;
                    l = (1 << m) - 1; c = (FL + 1) / 2 - m / 2;
                    b = (el < FL * FDIV) ? 1 : 0; d = (el == FL * FDIV) ? 1 : 0;
                end
                default: begin
                    t = el / SDIV;
                    l = (t % 2 == 1) ? (1 << N) - 1 : 0; c = 10; b = 1; d = 0;
                end
            endcase
        end
    endfunction

    always @(negedge clk) begin
        int l, c, b, d;
        model_out(l, c, b, d);
        chk("led_out", int'(led_out), l);
        chk("count",   int'(count),   c);
        chk("busy",    int'(busy),    b);
        chk("done",    int'(done),    d);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // press/release are issued right after a negedge
    task automatic press();
        start_n = 1'b0;
    endtask

    task automatic release_btn();
        start_n = 1'b1;
        step(4);
    endtask

    initial begin
        step(1);
        chk("rst_led", int'(led_out), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        step(2);
        rst = 1'b0;
        step(4);

        // slow fill
        mode = 2'b01; press(); step(3);
        chk("slow_init_count", int'(count), 10);
        chk("slow_init_led", int'(led_out), 0);
        chk("slow_init_busy", int'(busy), 1);
        step(4);
        chk("slow_tick1_led", int'(led_out), 'h001);
        chk("slow_tick1_count", int'(count), 9);
        step(36);
        chk("slow_done", int'(done), 1);
        chk("slow_done_led", int'(led_out), 'h3FF);
        chk("slow_done_count", int'(count), 0);
        step(1);
        chk("slow_hold_done", int'(done), 0);
        chk("slow_hold_busy", int'(busy), 0);
        chk("slow_hold_led", int'(led_out), 'h3FF);
        release_btn();

        // fast fill
        mode = 2'b10; press(); step(3);
        chk("fast_init_count", int'(count), 4);
        step(4);
        chk("fast_tick2_count", int'(count), 3);
        chk("fast_tick2_led", int'(led_out), 'h003);
        step(12);
        chk("fast_done", int'(done), 1);
        chk("fast_done_led", int'(led_out), 'h0FF);
        release_btn();

        // blink, 20 ticks
        mode = 2'b11; press(); step(3);
        chk("blink_count", int'(count), 10);
        step(4);
        chk("blink_on", int'(led_out), 'h3FF);
        step(4);
        chk("blink_off", int'(led_out), 0);
        step(72);
        release_btn();

        // abort from slow fill at 0x007
        mode = 2'b01; press(); step(3);
        release_btn();
        step(8);
        chk("abort_pre_led", int'(led_out), 'h007);
        mode = 2'b10; step(1);
        chk("abort_led", int'(led_out), 0);
        chk("abort_count", int'(count), 0);
        chk("abort_busy", int'(busy), 0);
        press(); step(3);
        chk("abort_restart_count", int'(count), 4);
        release_btn();
        step(20);

        // restart on the final slow tick
        mode = 2'b01; press(); step(3);
        start_n = 1'b1;
        step(37);
        press(); step(3);
        chk("restart_done", int'(done), 0);
        chk("restart_led", int'(led_out), 0);
        chk("restart_count", int'(count), 10);
        release_btn();

        // mode 00 with start
        mode = 2'b00; press(); step(3);
        chk("m00_busy", int'(busy), 0);
        chk("m00_led", int'(led_out), 0);
        release_btn();

        // reset during blink, button held through release
        mode = 2'b11; press(); step(10);
        #2 rst = 1'b1;
        #1;
        chk("arst_led", int'(led_out), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_busy", int'(busy), 0);
        step(2);
        rst = 1'b0;
        step(10);
        chk("arst_nostart", int'(busy), 0);
        release_btn();

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) start_n = ~start_n;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
